// File: rtl/iter_adder_if.sv
// iter_adder_if: request/result bundle for the iterative adder.
// The master drives operands and start; the slave returns status and results.
interface iter_adder_if #(
  parameter int WIDTH = 64
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ofl;
  logic             Zero;

  modport master (
    output start, sub, A, B, Cin,
    input  busy, done, S, Cout, Ofl, Zero
  );

  modport slave (
    input  start, sub, A, B, Cin,
    output busy, done, S, Cout, Ofl, Zero
  );
endinterface

// File: rtl/iter_adder.sv
// iter_adder: multi-cycle add/subtract, CHUNK bits per clock.
// Lookahead carries inside a chunk; only the inter-chunk carry is a flop.
module iter_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input logic         clk,
  input logic         rst_n,
  iter_adder_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ofl_q, ofl_d;
  logic             zero_q, zero_d;
  logic             busy, done;
  logic             accept, last;
  logic [CHUNK-1:0] ca, cb, csum;
  logic [CHUNK:0]   cc;

  // c[i] from group generate/propagate of bits below i and carry-in
  function automatic logic [CHUNK:0] cla(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             ci
  );
    logic [CHUNK:0] c;
    logic           gg;
    logic           pp;
    gg   = 1'b0;
    pp   = 1'b1;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      gg       = (x[i] & y[i]) | ((x[i] ^ y[i]) & gg);
      pp       = (x[i] ^ y[i]) & pp;
      c[i + 1] = gg | (pp & ci);
    end
    return c;
  endfunction

  assign accept = bus.start && (state_q != RUN);
  assign last   = (k_q == KW'(NCH - 1));
  assign ca     = a_q[int'(k_q) * CHUNK +: CHUNK];
  assign cb     = b_q[int'(k_q) * CHUNK +: CHUNK];
  assign cc     = cla(ca, cb, carry_q);
  assign csum   = ca ^ cb ^ cc[CHUNK-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      accept:                        state_d = RUN;
      (state_q == RUN) && last:      state_d = DONE;
      (state_q == DONE) && !bus.start: state_d = IDLE;
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    k_d     = k_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ofl_d   = ofl_q;
    zero_d  = zero_q;
    if (accept) begin
      a_d     = bus.A;
      b_d     = bus.B ^ {WIDTH{bus.sub}};
      carry_d = bus.sub | bus.Cin;
      k_d     = '0;
    end else if (state_q == RUN) begin
      s_d[int'(k_q) * CHUNK +: CHUNK] = csum;
      carry_d = cc[CHUNK];
      k_d     = k_q + 1'b1;
      if (last) begin
        k_d    = '0;
        cout_d = cc[CHUNK];
        ofl_d  = cc[CHUNK] ^ cc[CHUNK-1];
        zero_d = (s_d == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ofl_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ofl_q   <= ofl_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.Ofl  = ofl_q;
  assign bus.Zero = zero_q;
endmodule

// File: tb/tb_iter_adder.sv
// tb_iter_adder: directed and random checks of iter_adder
// against a whole-word arithmetic reference model.
module tb_iter_adder;
  localparam int WIDTH = 64;
  localparam int CHUNK = 16;
  localparam int NCH   = WIDTH / CHUNK;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  iter_adder_if #(.WIDTH(WIDTH)) bus ();

  iter_adder #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // {ofl, zero, cout, s}
  function automatic logic [66:0] model(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        ci,
    input logic        sb
  );
    logic [63:0] bx;
    logic [64:0] t;
    logic        ofl;
    bx  = sb ? ~b : b;
    t   = {1'b0, a} + {1'b0, bx} + 65'(sb ? 1'b1 : ci);
    ofl = (a[63] == bx[63]) && (t[63] != a[63]);
    return {ofl, t[63:0] == 64'd0, t[64], t[63:0]};
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [66:0] e);
    chk({tag, ".S"}, bus.S, e[63:0]);
    chk({tag, ".Cout"}, 64'(bus.Cout), 64'(e[64]));
    chk({tag, ".Zero"}, 64'(bus.Zero), 64'(e[65]));
    chk({tag, ".Ofl"}, 64'(bus.Ofl), 64'(e[66]));
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, ".busy"}, 64'(bus.busy), 64'd0);
    chk({tag, ".done"}, 64'(bus.done), 64'd0);
    chk_res(tag, 67'd0);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic ci, input logic sb, input string tag);
    logic [66:0] e;
    int          cyc;
    e = model(a, b, ci, sb);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = ci;
    bus.sub   = sb;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      bus.A   = r64();
      bus.B   = r64();
      bus.Cin = 1'($urandom);
      bus.sub = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".lat"}, 64'(cyc), 64'(NCH + 1));
    chk_res(tag, e);
    @(negedge clk);
    chk({tag, ".pulse"}, 64'(bus.done), 64'd0);
    chk({tag, ".idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [66:0] e;
    logic [66:0] q[$];
    logic [63:0] a, b;
    logic        ci, sb;
    int          dones, last_done, ops_left;

    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;

    #2 rst_n = 1'b0;
    #1 chk_zero_outs("rst0");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, "wrap");
    run_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, "xchunk");
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, "ovf");
    run_op(64'd5, 64'd7, 1'b1, 1'b1, "sub");

    // results hold in IDLE while inputs wander
    e = model(64'd5, 64'd7, 1'b1, 1'b1);
    bus.A = r64();
    bus.B = r64();
    repeat (3) @(negedge clk);
    chk_res("hold", e);

    // second start while busy is ignored
    @(negedge clk);
    bus.A = 64'd3; bus.B = 64'd4; bus.Cin = 1'b0; bus.sub = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.A = 64'd100; bus.B = 64'd100;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        chk_res("ign", model(64'd3, 64'd4, 1'b0, 1'b0));
      end
    end
    chk("ign.dones", 64'(dones), 64'd1);

    // reset mid-run aborts
    @(negedge clk);
    bus.A = r64(); bus.B = r64(); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_zero_outs("abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort.dones", 64'(dones), 64'd0);
    chk("abort.S", bus.S, 64'd0);
    run_op(64'd1, 64'd2, 1'b0, 1'b0, "post");

    // back-to-back with start held high
    @(negedge clk);
    a = r64(); b = r64(); ci = 1'($urandom); sb = 1'($urandom);
    bus.A = a; bus.B = b; bus.Cin = ci; bus.sub = sb;
    bus.start = 1'b1;
    q.push_back(model(a, b, ci, sb));
    ops_left  = 7;
    last_done = 0;
    for (int cyc = 1; cyc <= 100 && q.size() > 0; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        e = q.pop_front();
        chk_res("b2b", e);
        chk("b2b.period", 64'(cyc - last_done), 64'(NCH + 1));
        last_done = cyc;
        if (ops_left > 0) begin
          a = r64(); b = r64(); ci = 1'($urandom); sb = 1'($urandom);
          bus.A = a; bus.B = b; bus.Cin = ci; bus.sub = sb;
          q.push_back(model(a, b, ci, sb));
          ops_left--;
        end else begin
          bus.start = 1'b0;
        end
      end else begin
        bus.A   = r64();
        bus.B   = r64();
        bus.Cin = 1'($urandom);
        bus.sub = 1'($urandom);
      end
    end
    bus.start = 1'b0;
    chk("b2b.drain", 64'(q.size()), 64'd0);

    // random operands, biased toward carry chains
    for (int i = 0; i < 16; i++) begin
      a = r64();
      b = r64();
      if ($urandom_range(0, 2) == 0) a = 64'hFFFF_FFFF_FFFF_FFFF >> $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) b = a;
      run_op(a, b, 1'($urandom), 1'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iter_adder.md
ITER_ADDER -- requirements
Module: iter_adder

Interface
REQ-001 Parameter: WIDTH, default 64, operand/result width; SHALL be a multiple of CHUNK and >= CHUNK.
REQ-002 Parameter: CHUNK, default 16, bits added per cycle; NCH = WIDTH/CHUNK chunk steps per operation.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  request; sampled only when busy=0.
REQ-006 Port: sub  input  1  0 = A+B+Cin, 1 = A-B (A + ~B + 1, Cin ignored).
REQ-007 Port: A, B  input  WIDTH  operands, sampled with start.
REQ-008 Port: Cin  input  1  carry-in, sampled with start.
REQ-009 Port: busy  output  1  operation in progress; start ignored.
REQ-010 Port: done  output  1  one-cycle pulse; result outputs valid.
REQ-011 Port: S  output  WIDTH  sum/difference.
REQ-012 Port: Cout  output  1  carry out of bit WIDTH-1 (sub: 1 = no borrow).
REQ-013 Port: Ofl  output  1  signed two's-complement overflow.
REQ-014 Port: Zero  output  1  S == 0.

Function
REQ-015 States: IDLE, RUN, DONE; encoding free.
REQ-016 IDLE, start=1 at edge E0: SHALL capture A, B^{WIDTH{sub}}, carry = sub ? 1 : Cin, chunk index k=0; go RUN.
REQ-017 RUN, each edge: SHALL add captured chunk k of A and B with carry register, write S[k*CHUNK +: CHUNK], update carry to chunk carry-out, k=k+1.
REQ-018 RUN SHALL last exactly NCH edges (E1..E_NCH); at E_NCH go DONE.
REQ-019 Chunk add SHALL be combinational carry-lookahead within the chunk; only the inter-chunk carry is registered.
REQ-020 At E_NCH: Cout = final carry; Ofl = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; Zero = (final S == 0).
REQ-021 Latency: done=1 in the cycle after E_NCH, i.e. NCH cycles after start is sampled; exactly one cycle.
REQ-022 busy=1 from E0 through E_NCH (states RUN), 0 in IDLE and DONE.
REQ-023 S, Cout, Ofl, Zero SHALL hold their final values in DONE and IDLE until the next accepted start; S, Cout, Ofl, Zero updating mid-RUN is permitted, values only guaranteed when done=1 or afterwards.
REQ-024 DONE, start=1: SHALL be accepted as in IDLE (back-to-back, no bubble); start=0: go IDLE.
REQ-025 start while busy=1 SHALL be ignored; A/B/Cin/sub changes during RUN SHALL not affect the result.
REQ-026 NCH=1 SHALL work: done the cycle after start.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, k=0, carry=0, busy=0, done=0, S=0, Cout=0, Ofl=0, Zero=0.
REQ-028 Reset during RUN SHALL abort the operation with no done pulse; first start after rst_n=1 SHALL behave as from power-up.

Verification (WIDTH=64, CHUNK=16)
REQ-029 A=0xFFFF_FFFF_FFFF_FFFF, B=1, Cin=0, sub=0 -> done 4 cycles later, S=0, Cout=1, Zero=1, Ofl=0.
REQ-030 A=0x0000_0000_FFFF_FFFF, B=1 -> S=0x0000_0001_0000_0000, Cout=0 (inter-chunk carry).
REQ-031 A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> S=0x8000_0000_0000_0000, Ofl=1, Cout=0; sub=1, A=5, B=7, Cin=1 -> S=0xFFFF_FFFF_FFFF_FFFE, Cout=0, Ofl=0.
REQ-032 start with A=3,B=4, then start with A=100,B=100 two cycles later -> second ignored, S=7, single done pulse.
REQ-033 rst_n low 2 cycles after start -> all outputs 0 immediately, no done; new start A=1,B=2 -> S=3.
REQ-034 start held high continuously with new operands each done cycle -> done every 5 cycles (start, 4 RUN... back-to-back from DONE), each result correct.
